// File: rtl/cla8_operand_loader.sv
// cla8_operand_loader: serial LSB-first frame receiver presenting A/B/cin to the CLA8 adder core.
// Ports: clk/rst_n (async active-low); ser_data/ser_valid/ser_start in, ser_ready out (serial side);
//        a/b/cin/op_valid out, op_ready in (operand handshake); frame_err one-cycle restart pulse.
module cla8_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_data,
    input  logic             ser_valid,
    input  logic             ser_start,
    output logic             ser_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             cin,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             frame_err
);
    localparam int FL = 2*WIDTH+1;
    localparam int CW = $clog2(2*WIDTH+2);
    // DRAIN is the HOLD->IDLE cycle that keeps ser_ready low after consumption.
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DRAIN} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FL-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic            cin_q, cin_d, err_q, err_d;
    logic            accept;
    logic [FL-1:0]   sr_shift;
    assign ser_ready = (state_q == IDLE) || (state_q == SHIFT);
    assign op_valid  = state_q == HOLD;
    assign accept    = ser_valid && ser_ready;
    // Right shift: after 2*WIDTH+1 shifts the first bit received sits at index 0.
    assign sr_shift  = {ser_data, sr_q[FL-1:1]};
    assign a         = a_q;
    assign b         = b_q;
    assign cin       = cin_q;
    assign frame_err = err_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (accept && ser_start) begin
                sr_d    = sr_shift;
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end
            SHIFT: if (accept) begin
                sr_d = sr_shift;
                if (ser_start) begin
                    err_d = 1'b1;
                    cnt_d = CW'(1);
                end else if (cnt_q == CW'(FL-1)) begin
                    a_d     = sr_shift[WIDTH-1:0];
                    b_d     = sr_shift[2*WIDTH-1:WIDTH];
                    cin_d   = sr_shift[FL-1];
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: if (op_ready) state_d = DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/cla8_operand_loader.md
# cla8_operand_loader

Serial-to-parallel operand receiver for the 8-bit carry-lookahead adder datapath. It accepts a framed, LSB-first bitstream carrying operand A, operand B and carry-in, assembles the bits in an internal shift register, and presents a complete operand set to the adder core through a valid/ready handshake. It is the fan-out end of the adder's bit-level interface: where the gate-level reduction trees collapse many bits into one, this block expands one serial bit into the full parallel operand word.

## Interface
- WIDTH, 8, operand width in bits; frame length is 2*WIDTH+1 bits.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- ser_data  input  1  serial data bit.
- ser_valid  input  1  ser_data is valid this cycle.
- ser_start  input  1  qualifies the current bit as frame bit 0; sampled only with ser_valid.
- ser_ready  output  1  block accepts a bit this cycle.
- a  output  WIDTH  operand A.
- b  output  WIDTH  operand B.
- cin  output  1  carry-in.
- op_valid  output  1  a/b/cin hold a complete frame.
- op_ready  input  1  adder consumes the operand set.
- frame_err  output  1  one-cycle pulse: frame restarted before completion.

## Operation
- One clock and one reset: clk; rst_n is asynchronous and active-low.
- Frame order: A[0]..A[WIDTH-1], then B[0]..B[WIDTH-1], then cin. 17 bits at WIDTH=8.
- A bit is accepted when ser_valid && ser_ready.
- States:
  - IDLE: ser_ready=1. An accepted bit with ser_start=0 is discarded. An accepted bit with ser_start=1 is stored as bit 0, count:=1, and the state moves to SHIFT.
  - SHIFT: ser_ready=1. Each accepted bit is stored and count increments.
    - An accepted bit with ser_start=1 pulses frame_err. That bit becomes the new bit 0, count:=1, and the state stays SHIFT. The partial frame is dropped.
    - When the accepted bit is bit 2*WIDTH (the last), the shift register is copied to a/b/cin, op_valid:=1, and the state moves to HOLD.
  - HOLD: ser_ready=0 and op_valid=1. a/b/cin are stable. On op_ready=1: op_valid:=0, state:=IDLE. ser_ready stays 0 in that cycle.
- a/b/cin change only on frame completion. They keep their last values after consumption.
- Counter width is $clog2(2*WIDTH+2) and never wraps; it is cleared on entry to IDLE or HOLD.
- ser_ready is decoded from the registered state only. It has no combinational path from op_ready.
- ser_start/ser_data are ignored when ser_valid=0.

## Timing
- Reset values: a=0, b=0, cin=0, op_valid=0, frame_err=0, state IDLE, so ser_ready=1 during and after reset.
- Latency: op_valid rises on the clock edge that accepts the last bit; it is visible the next cycle.
  - The minimum frame is 2*WIDTH+1 consecutive cycles. op_valid is high on cycle 2*WIDTH+2 counted from the start bit.
- frame_err is high for exactly the cycle after the offending accept.
- Back-to-back frames: at least one idle-accept gap, because the HOLD->IDLE cycle has ser_ready=0.
  - Maximum throughput is one frame per 2*WIDTH+3 cycles with op_ready held at 1.
- Reset mid-frame or in HOLD: outputs return to their reset values immediately. The partial frame is discarded and no frame_err is generated.
- op_ready while op_valid=0 has no effect.

## Test plan
- Basic frame: A=0x5A, B=0xC3, cin=1, sent LSB-first with ser_start on the first bit and op_ready=1 -> op_valid=1 for one cycle with a=0x5A, b=0xC3, cin=1, 18 cycles after the start bit.
- Backpressure: same frame with op_ready=0 for 10 cycles ->
  - op_valid and a/b/cin are held stable, and ser_ready=0 throughout.
  - On op_ready=1, op_valid falls next cycle and ser_ready returns one cycle later.
- Idle noise and ser_valid gaps:
  - Five bits with ser_start=0 in IDLE are ignored.
  - The frame A=0xFF, B=0x01, cin=0 with random ser_valid gaps then yields a=0xFF, b=0x01, cin=0.
- Restart: a second ser_start after 6 bits of frame A=0x11 -> frame_err pulses one cycle. The following full frame A=0x80, B=0x7F, cin=1 is delivered intact.
- Reset mid-frame: rst_n asserted low after 9 bits -> all outputs return to 0 asynchronously. The next full frame A=0x00, B=0xFF, cin=1 is received correctly.
- Back-to-back: three frames streamed with op_ready=1 -> three op_valid pulses spaced 19 cycles apart, each carrying its own operand set, with no lost or merged bits.
